sha_job_rx: RTL and testbench

- Upstream stage of the SHA256 mining core.
- Sits between the UART receive/transmit byte interfaces and sha256_double.
- Detects the 'H' handshake and collects the 136-byte job frame: 64 data, 32 state, 32 target, 4 nonce_base, 4 position.
- Presents the assembled job with a valid/ready handshake and emits single-byte status responses ('1', 'S', 'E') toward the UART transmitter.

---
 rtl/sha_job_pkg.sv | 22 ++
 rtl/sha_job_rx.sv | 165 ++++++++++++++++
 tb/tb_sha_job_rx.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_job_pkg.sv
// Shared types and constants for the SHA job receiver: FSM states, frame layout
// and the single-byte protocol characters.
package sha_job_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    HOLD
  } job_state_t;

  localparam int unsigned JOB_BYTES  = 136;
  localparam int unsigned OFS_STATE  = 64;
  localparam int unsigned OFS_TARGET = 96;
  localparam int unsigned OFS_NONCE  = 128;
  localparam int unsigned OFS_POS    = 132;

  localparam logic [7:0] RSP_ACK       = 8'h31;  // '1'
  localparam logic [7:0] RSP_START     = 8'h53;  // 'S'
  localparam logic [7:0] RSP_ERR       = 8'h45;  // 'E'
  localparam logic [7:0] CMD_HANDSHAKE = 8'h48;  // 'H'

endpackage

// File: rtl/sha_job_rx.sv
// Job frame receiver: 'H' handshake, 136-byte frame capture, job valid/ready hold and
// single-byte status responses toward the UART transmitter.
module sha_job_rx
  import sha_job_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned CNT_W          = 21
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_rx_valid,
  input  logic [7:0]   in_rx_data,
  output logic         out_rx_ready,
  output logic         out_tx_valid,
  output logic [7:0]   out_tx_data,
  input  logic         in_tx_ready,
  output logic         out_job_valid,
  input  logic         in_job_ready,
  output logic [511:0] out_job_data,
  output logic [255:0] out_job_state,
  output logic [255:0] out_job_target,
  output logic [31:0]  out_job_nonce_base,
  output logic [31:0]  out_job_position,
  output logic         out_err
);

  localparam logic [7:0]       LastByte = 8'(JOB_BYTES - 1);
  localparam logic [CNT_W-1:0] TmoMax   = CNT_W'(TIMEOUT_CYCLES);

  job_state_t             state_q, state_d;
  logic [7:0]             byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]       tmo_q, tmo_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   job_valid_q, job_valid_d;
  logic                   err_q, err_d;
  logic [JOB_BYTES*8-1:0] job_q;

  logic rx_ready;
  logic rx_fire;
  logic tx_free;
  logic wr_en;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_d       = tmo_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    job_valid_d = job_valid_q;
    err_d       = 1'b0;
    wr_en       = 1'b0;

    rx_ready = ((state_q == IDLE) || (state_q == RECV)) && !tx_valid_q;
    rx_fire  = in_rx_valid && rx_ready;
    // Response register may be reloaded in the same cycle it drains.
    tx_free  = !tx_valid_q || in_tx_ready;

    if (tx_valid_q && in_tx_ready) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (rx_fire) begin
          tx_valid_d = 1'b1;
          if (in_rx_data == CMD_HANDSHAKE) begin
            tx_data_d  = RSP_ACK;
            byte_cnt_d = '0;
            state_d    = RECV;
          end else begin
            tx_data_d = RSP_ERR;
            err_d     = 1'b1;
          end
        end
      end

      RECV: begin
        if (rx_fire) begin
          wr_en = 1'b1;
          tmo_d = '0;
          if (byte_cnt_q == LastByte) begin
            byte_cnt_d  = '0;
            job_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          if (tmo_q >= TmoMax) begin
            // Counter sits saturated until the error byte can be loaded.
            if (tx_free) begin
              tx_valid_d = 1'b1;
              tx_data_d  = RSP_ERR;
              err_d      = 1'b1;
              tmo_d      = '0;
              byte_cnt_d = '0;
              state_d    = IDLE;
            end
          end else begin
            tmo_d = tmo_q + CNT_W'(1);
          end
        end
      end

      HOLD: begin
        if (job_valid_q && in_job_ready) begin
          job_valid_d = 1'b0;
        end
        if ((!job_valid_q || in_job_ready) && tx_free) begin
          tx_valid_d = 1'b1;
          tx_data_d  = RSP_START;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      tmo_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      job_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_q       <= tmo_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      job_valid_q <= job_valid_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      job_q <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < JOB_BYTES; k++) begin
        if (byte_cnt_q == 8'(k)) begin
          job_q[8*k +: 8] <= in_rx_data;
        end
      end
    end
  end

  assign out_rx_ready       = rx_ready;
  assign out_tx_valid       = tx_valid_q;
  assign out_tx_data        = tx_data_q;
  assign out_job_valid      = job_valid_q;
  assign out_err            = err_q;
  assign out_job_data       = job_q[0 +: 512];
  assign out_job_state      = job_q[OFS_STATE*8 +: 256];
  assign out_job_target     = job_q[OFS_TARGET*8 +: 256];
  assign out_job_nonce_base = job_q[OFS_NONCE*8 +: 32];
  assign out_job_position   = job_q[OFS_POS*8 +: 32];

endmodule

// File: tb/tb_sha_job_rx.sv
// Directed plus randomized bench for sha_job_rx against a byte-level protocol model.
module tb_sha_job_rx;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_rx_valid;
  logic [7:0]   in_rx_data;
  logic         out_rx_ready;
  logic         out_tx_valid;
  logic [7:0]   out_tx_data;
  logic         in_tx_ready;
  logic         out_job_valid;
  logic         in_job_ready;
  logic [511:0] out_job_data;
  logic [255:0] out_job_state;
  logic [255:0] out_job_target;
  logic [31:0]  out_job_nonce_base;
  logic [31:0]  out_job_position;
  logic         out_err;

  always #5 clk = ~clk;

  sha_job_rx #(
    .TIMEOUT_CYCLES(50),
    .CNT_W         (8)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .in_rx_valid       (in_rx_valid),
    .in_rx_data        (in_rx_data),
    .out_rx_ready      (out_rx_ready),
    .out_tx_valid      (out_tx_valid),
    .out_tx_data       (out_tx_data),
    .in_tx_ready       (in_tx_ready),
    .out_job_valid     (out_job_valid),
    .in_job_ready      (in_job_ready),
    .out_job_data      (out_job_data),
    .out_job_state     (out_job_state),
    .out_job_target    (out_job_target),
    .out_job_nonce_base(out_job_nonce_base),
    .out_job_position  (out_job_position),
    .out_err           (out_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Observed traffic and the model's expectation of it.
  logic [7:0] tx_log[$];
  logic [7:0] exp_tx[$];
  int         err_seen = 0;
  int         exp_err  = 0;

  // Byte-level protocol model.
  logic [7:0] m_frame[136];
  bit         m_in_frame = 0;
  int         m_cnt      = 0;

  always @(negedge clk) begin
    #1;
    if (rstn === 1'b1 && out_tx_valid === 1'b1 && in_tx_ready === 1'b1) begin
      tx_log.push_back(out_tx_data);
    end
    if (out_err === 1'b1) err_seen++;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0;
    m_cnt      = 0;
    for (int k = 0; k < 136; k++) m_frame[k] = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!m_in_frame) begin
      if (b == 8'h48) begin
        exp_tx.push_back(8'h31);
        m_in_frame = 1;
        m_cnt      = 0;
      end else begin
        exp_tx.push_back(8'h45);
        exp_err++;
      end
    end else begin
      m_frame[m_cnt] = b;
      m_cnt++;
      if (m_cnt == 136) m_in_frame = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_rx_valid = 1'b1;
    in_rx_data  = b;
    #1;
    while (!out_rx_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rx_accept", 512'(out_rx_ready), 512'(1));
    @(posedge clk);
    #1;
    in_rx_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_tx(input string tag);
    int n;
    chk({tag, "_txlen"}, 512'(tx_log.size()), 512'(exp_tx.size()));
    n = (tx_log.size() < exp_tx.size()) ? tx_log.size() : exp_tx.size();
    for (int i = 0; i < n; i++) chk({tag, "_txbyte"}, 512'(tx_log[i]), 512'(exp_tx[i]));
    chk({tag, "_errcnt"}, 512'(err_seen), 512'(exp_err));
  endtask

  task automatic check_job(input string tag);
    logic [1087:0] e;
    for (int k = 0; k < 136; k++) e[8*k +: 8] = m_frame[k];
    chk({tag, "_data"}, out_job_data, e[511:0]);
    chk({tag, "_state"}, 512'(out_job_state), 512'(e[767:512]));
    chk({tag, "_target"}, 512'(out_job_target), 512'(e[1023:768]));
    chk({tag, "_nonce"}, 512'(out_job_nonce_base), 512'(e[1055:1024]));
    chk({tag, "_pos"}, 512'(out_job_position), 512'(e[1087:1056]));
  endtask

  task automatic accept_job(input string tag);
    @(negedge clk);
    in_job_ready = 1'b1;
    @(posedge clk);
    #1;
    in_job_ready = 1'b0;
    chk({tag, "_valid_drop"}, 512'(out_job_valid), 512'(0));
    exp_tx.push_back(8'h53);
    idle(4);
    check_tx(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 512'(out_rx_ready), 512'(1));
    chk({tag, "_tx_valid"}, 512'(out_tx_valid), 512'(0));
    chk({tag, "_tx_data"}, 512'(out_tx_data), 512'(0));
    chk({tag, "_job_valid"}, 512'(out_job_valid), 512'(0));
    chk({tag, "_err"}, 512'(out_err), 512'(0));
    chk({tag, "_data"}, out_job_data, 512'(0));
    chk({tag, "_state"}, 512'(out_job_state), 512'(0));
    chk({tag, "_target"}, 512'(out_job_target), 512'(0));
    chk({tag, "_nonce"}, 512'(out_job_nonce_base), 512'(0));
    chk({tag, "_pos"}, 512'(out_job_position), 512'(0));
  endtask

  initial begin
    int base;
    logic [7:0] b;
    rstn         = 1'b0;
    in_rx_valid  = 1'b0;
    in_rx_data   = 8'h00;
    in_tx_ready  = 1'b1;
    in_job_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // Handshake then a counting frame.
    send_byte(8'h48);
    idle(3);
    check_tx("hs");
    for (int i = 0; i < 136; i++) begin
      send_byte(8'(i));
      if (i == 134) chk("f1_valid_early", 512'(out_job_valid), 512'(0));
    end
    chk("f1_valid", 512'(out_job_valid), 512'(1));
    chk("f1_data0", 512'(out_job_data[7:0]), 512'(8'h00));
    chk("f1_state0", 512'(out_job_state[7:0]), 512'(8'h40));
    chk("f1_tgt31", 512'(out_job_target[255:248]), 512'(8'h7F));
    chk("f1_nonce", 512'(out_job_nonce_base), 512'(32'h83828180));
    chk("f1_pos", 512'(out_job_position), 512'(32'h87868584));
    check_job("f1");
    // Bytes offered while held must not be taken.
    @(negedge clk);
    in_rx_valid = 1'b1;
    in_rx_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("f1_hold_rx_ready", 512'(out_rx_ready), 512'(0));
      chk("f1_hold_valid", 512'(out_job_valid), 512'(1));
    end
    in_rx_valid = 1'b0;
    check_job("f1_hold");
    accept_job("f1_acc");

    // Non-handshake byte in idle, then a handshake.
    send_byte(8'h58);
    idle(3);
    check_tx("bad");
    send_byte(8'h48);
    idle(3);
    check_tx("bad_hs");

    // Random frame with an 'H' as payload byte 10 and random gaps.
    for (int i = 0; i < 136; i++) begin
      b = (i == 10) ? 8'h48 : 8'($urandom_range(0, 255));
      send_byte(b);
      idle($urandom_range(0, 3));
    end
    idle(1);
    #1;
    chk("f2_valid", 512'(out_job_valid), 512'(1));
    chk("f2_byte10", 512'(out_job_data[87:80]), 512'(8'h48));
    check_job("f2");
    check_tx("f2");
    idle($urandom_range(1, 6));
    accept_job("f2_acc");

    // Inter-byte timeout after 20 payload bytes.
    send_byte(8'h48);
    for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(0, 255)));
    base = tx_log.size();
    idle(45);
    #1;
    chk("tmo_early_tx", 512'(tx_log.size()), 512'(base));
    chk("tmo_early_err", 512'(err_seen), 512'(exp_err));
    for (int n = 0; n < 30 && tx_log.size() == base; n++) begin
      @(negedge clk);
      #1;
    end
    exp_tx.push_back(8'h45);
    exp_err++;
    m_in_frame = 0;
    idle(3);
    check_tx("tmo");
    send_byte(8'h48);
    for (int i = 0; i < 136; i++) send_byte(8'($urandom_range(0, 255)));
    idle(1);
    #1;
    chk("f3_valid", 512'(out_job_valid), 512'(1));
    check_job("f3");
    accept_job("f3_acc");

    // Pending response backpressures rx; then reset mid-frame.
    @(negedge clk);
    in_tx_ready = 1'b0;
    send_byte(8'h48);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("bp_rx_ready", 512'(out_rx_ready), 512'(0));
      chk("bp_tx_valid", 512'(out_tx_valid), 512'(1));
      chk("bp_tx_data", 512'(out_tx_data), 512'(8'h31));
    end
    @(negedge clk);
    in_tx_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_rx_ready_after", 512'(out_rx_ready), 512'(1));
    for (int i = 0; i < 30; i++) send_byte(8'($urandom_range(0, 255)));
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    idle(3);
    check_tx("midrst");
    send_byte(8'h48);
    idle(3);
    check_tx("post_rst_hs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
